// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a held CPU load/store into a decoded SETUP/ACCESS APB transfer.
// Latency: 3 stall cycles at zero wait, +1 per wait state; 1 on decode error; TIMEOUT+2 on abort.
// Backpressure: core is stalled while the transfer is pending; slaves throttle via PREADY, bounded by TIMEOUT.
module apb_master_bridge #(
    parameter int          NUM_SLAVES = 4,
    parameter logic [15:0] BASE_HI    = 16'h0001,
    parameter int          TIMEOUT    = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    output logic [31:0]              cpu_rdata,
    output logic                     cpu_stall,
    output logic                     cpu_err,
    output logic [31:0]              PADDR,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    input  logic [32*NUM_SLAVES-1:0] PRDATA_in,
    input  logic [NUM_SLAVES-1:0]    PREADY_in,
    input  logic [NUM_SLAVES-1:0]    PSLVERR_in
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  sel_idx;
    logic [7:0]  wait_cnt;
    logic        decode_ok;
    logic        sel_ready;
    logic        sel_err;
    logic [31:0] sel_rdata;

    // Decode the live request address: peripheral window and an existing slave slot
    assign decode_ok = (cpu_addr[31:16] == BASE_HI) &&
                       ({30'd0, cpu_addr[13:12]} < 32'(NUM_SLAVES));

    // Response mux: only the addressed slave's PREADY/PRDATA/PSLVERR are looked at
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == i[1:0]) begin
                sel_ready = PREADY_in[i];
                sel_err   = PSLVERR_in[i];
                sel_rdata = PRDATA_in[32*i +: 32];
            end
        end
    end

    // Select is decoded from state so an async reset drops it without waiting for a clock
    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if ((state == ST_SETUP || state == ST_ACCESS) && sel_idx == i[1:0]) begin
                PSEL[i] = 1'b1;
            end
        end
    end

    assign PENABLE   = (state == ST_ACCESS);
    // RESP releases the core; reset also masks the stall
    assign cpu_stall = cpu_req && (state != ST_RESP) && !PRESETn;

    // Transfer sequencing: capture in IDLE, APB phases, completion/abort into RESP
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state     <= ST_IDLE;
            sel_idx   <= '0;
            wait_cnt  <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        PADDR     <= cpu_addr;
                        PWRITE    <= cpu_we;
                        PWDATA    <= cpu_wdata;
                        sel_idx   <= cpu_addr[13:12];
                        wait_cnt  <= '0;
                        cpu_rdata <= '0;
                        if (decode_ok) begin
                            cpu_err <= 1'b0;
                            state   <= ST_SETUP;
                        end else begin
                            // Nothing answers this address: report straight away, no bus cycle
                            cpu_err <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (sel_ready) begin
                        cpu_err   <= sel_err;
                        cpu_rdata <= PWRITE ? 32'd0 : sel_rdata;
                        state     <= ST_RESP;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th access cycle without ready: give up
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Request still held here belongs to the completing instruction
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;
    localparam int NS = 4;
    localparam int TO = 8;

    logic PCLK = 1'b0;
    logic PRESETn;
    logic cpu_req, cpu_we, cpu_stall, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [31:0] PADDR, PWDATA;
    logic [NS-1:0] PSEL;
    logic PENABLE, PWRITE;
    logic [32*NS-1:0] PRDATA_in;
    logic [NS-1:0] PREADY_in, PSLVERR_in;

    // Second instance with three slaves for the slot-range decode
    logic cpu_req3, cpu_we3, cpu_stall3, cpu_err3;
    logic [31:0] cpu_addr3, cpu_wdata3, cpu_rdata3, PADDR3, PWDATA3;
    logic [2:0] PSEL3, PREADY3, PSLVERR3;
    logic PENABLE3, PWRITE3;
    logic [95:0] PRDATA3;

    apb_master_bridge #(.NUM_SLAVES(NS), .BASE_HI(16'h0001), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_err(cpu_err), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA_in(PRDATA_in),
        .PREADY_in(PREADY_in), .PSLVERR_in(PSLVERR_in));

    apb_master_bridge #(.NUM_SLAVES(3), .BASE_HI(16'h0001), .TIMEOUT(255)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .cpu_req(cpu_req3), .cpu_we(cpu_we3),
        .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3), .cpu_rdata(cpu_rdata3),
        .cpu_stall(cpu_stall3), .cpu_err(cpu_err3), .PADDR(PADDR3), .PSEL(PSEL3),
        .PENABLE(PENABLE3), .PWRITE(PWRITE3), .PWDATA(PWDATA3), .PRDATA_in(PRDATA3),
        .PREADY_in(PREADY3), .PSLVERR_in(PSLVERR3));

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    // Observations from the last transfer (cycle 0 = request cycle)
    int o_resp, o_sel_first, o_sel_last, o_en_first, o_en_last, o_addr_moves;
    logic [NS-1:0] o_sel_or, o_idle_sel;
    logic [31:0] o_paddr, o_pwdata, o_rdata, o_idle_rdata, o_paddr_end;
    logic o_pwrite, o_err, o_idle_err, o_idle_stall;

    // Reference model: stall length from the transfer rules
    function automatic int exp_resp(input logic [31:0] a, input int waits);
        if (a[31:16] != 16'h0001 || int'(a[13:12]) >= NS) return 1;
        return (waits < TO) ? 3 + waits : TO + 2;
    endfunction

    function automatic logic exp_ok(input logic [31:0] a);
        return (a[31:16] == 16'h0001) && (int'(a[13:12]) < NS);
    endfunction

    // Drives one request and a reactive slave; records what the bus did. Enters/leaves at posedge+1.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] sl_rdata, input logic sl_err,
                           input logic keep);
        int idx = int'(addr[13:12]);
        int acc = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        PRDATA_in = {$urandom, $urandom, $urandom, $urandom};
        PSLVERR_in = NS'($urandom);
        PREADY_in = NS'($urandom);
        PRDATA_in[32*idx +: 32] = sl_rdata;
        PSLVERR_in[idx] = sl_err;
        PREADY_in[idx] = 1'b0;
        o_resp = -1; o_sel_first = -1; o_sel_last = -1; o_en_first = -1; o_en_last = -1;
        o_addr_moves = 0; o_sel_or = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge PCLK);
            if (PSEL != '0) begin
                if (o_sel_first < 0) begin
                    o_sel_first = c; o_paddr = PADDR; o_pwdata = PWDATA; o_pwrite = PWRITE;
                end else if (PADDR != o_paddr || PWDATA != o_pwdata || PWRITE != o_pwrite) begin
                    o_addr_moves++;
                end
                o_sel_last = c;
                o_sel_or |= PSEL;
            end
            if (PENABLE) begin
                if (o_en_first < 0) o_en_first = c;
                o_en_last = c;
            end
            if (!cpu_stall) begin
                o_resp = c; o_rdata = cpu_rdata; o_err = cpu_err; o_paddr_end = PADDR;
                break;
            end
            PREADY_in = NS'($urandom);
            PREADY_in[idx] = PENABLE && PSEL[idx] && (acc == waits);
            if (PENABLE) acc++;
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        if (!keep) begin
            cpu_req = 1'b0; cpu_addr = $urandom; cpu_we = 1'($urandom); cpu_wdata = $urandom;
            PREADY_in = NS'($urandom);
            PRDATA_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge PCLK);
            o_idle_stall = cpu_stall; o_idle_sel = PSEL; o_idle_rdata = cpu_rdata; o_idle_err = cpu_err;
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h0001_3004; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checks++; if (PSEL !== '0) begin errors++; $display("FAIL reset_psel: got %b want 0", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b want 0", PENABLE); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'd0 || cpu_err !== 1'b0) begin errors++; $display("FAIL reset_resp: rdata %h err %b want 0/0", cpu_rdata, cpu_err); end
        checks++; if (PADDR !== 32'd0 || PWDATA !== 32'd0 || PWRITE !== 1'b0) begin errors++; $display("FAIL reset_bus: paddr %h pwdata %h pwrite %b want zeros", PADDR, PWDATA, PWRITE); end
        cpu_req = 1'b0;
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_store_zero_wait();
        do_xfer(1'b1, 32'h0001_3004, 32'hA5A5_5A5A, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++; if (o_resp !== 3) begin errors++; $display("FAIL store_stall: got %0d want 3", o_resp); end
        checks++; if (o_sel_or !== 4'b1000) begin errors++; $display("FAIL store_psel: got %b want 1000", o_sel_or); end
        checks++; if (o_sel_first !== 1 || o_sel_last !== 2) begin errors++; $display("FAIL store_psel_cycles: got %0d..%0d want 1..2", o_sel_first, o_sel_last); end
        checks++; if (o_en_first !== 2 || o_en_last !== 2) begin errors++; $display("FAIL store_penable_cycles: got %0d..%0d want 2..2", o_en_first, o_en_last); end
        checks++; if (o_pwdata !== 32'hA5A5_5A5A || o_pwrite !== 1'b1 || o_paddr !== 32'h0001_3004) begin errors++; $display("FAIL store_bus: got %h/%b/%h want 00013004/1/a5a55a5a", o_paddr, o_pwrite, o_pwdata); end
        checks++; if (o_err !== 1'b0 || o_rdata !== 32'd0) begin errors++; $display("FAIL store_resp: err %b rdata %h want 0/0", o_err, o_rdata); end
        checks++; if (o_idle_stall !== 1'b0 || o_idle_sel !== '0) begin errors++; $display("FAIL store_idle: stall %b psel %b want 0/0", o_idle_stall, o_idle_sel); end
    endtask

    task automatic test_load_wait();
        do_xfer(1'b0, 32'h0001_2000, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
        checks++; if (o_resp !== 5) begin errors++; $display("FAIL load_stall: got %0d want 5", o_resp); end
        checks++; if (o_rdata !== 32'h1234_5678 || o_err !== 1'b0) begin errors++; $display("FAIL load_rdata: got %h err %b want 12345678/0", o_rdata, o_err); end
        checks++; if (o_addr_moves !== 0 || o_paddr !== 32'h0001_2000) begin errors++; $display("FAIL load_paddr_stable: moves %0d paddr %h want 0/00012000", o_addr_moves, o_paddr); end
        checks++; if (o_en_first !== 2 || o_en_last !== 4) begin errors++; $display("FAIL load_access_cycles: got %0d..%0d want 2..4", o_en_first, o_en_last); end
        checks++; if (o_idle_rdata !== 32'h1234_5678 || o_paddr_end !== 32'h0001_2000) begin errors++; $display("FAIL load_hold: rdata %h paddr %h want 12345678/00012000", o_idle_rdata, o_paddr_end); end
    endtask

    task automatic test_slverr();
        do_xfer(1'b0, 32'h0001_1010, 32'h0, 1, 32'h0BAD_F00D, 1'b1, 1'b0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL slverr_err: got %b want 1", o_err); end
        checks++; if (o_resp !== 4 || o_sel_or !== 4'b0010) begin errors++; $display("FAIL slverr_normal_end: resp %0d psel %b want 4/0010", o_resp, o_sel_or); end
        checks++; if (o_idle_err !== 1'b1) begin errors++; $display("FAIL slverr_hold: got %b want 1", o_idle_err); end
    endtask

    task automatic test_decode_err();
        do_xfer(1'b0, 32'h0002_0000, 32'h0, 0, 32'h1111_1111, 1'b0, 1'b0);
        checks++; if (o_sel_first !== -1 || o_en_first !== -1) begin errors++; $display("FAIL decode_no_psel: first psel %0d penable %0d want -1/-1", o_sel_first, o_en_first); end
        checks++; if (o_resp !== 1 || o_err !== 1'b1) begin errors++; $display("FAIL decode_resp: resp %0d err %b want 1/1", o_resp, o_err); end
        // Slot 3 does not exist with three slaves
        cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 32'h0001_3000;
        @(negedge PCLK);
        checks++; if (PSEL3 !== 3'b000 || cpu_stall3 !== 1'b1) begin errors++; $display("FAIL ns3_decode_c0: psel %b stall %b want 000/1", PSEL3, cpu_stall3); end
        @(posedge PCLK); #1;
        @(negedge PCLK);
        checks++; if (PSEL3 !== 3'b000 || cpu_stall3 !== 1'b0 || cpu_err3 !== 1'b1) begin errors++; $display("FAIL ns3_decode_c1: psel %b stall %b err %b want 000/0/1", PSEL3, cpu_stall3, cpu_err3); end
        @(posedge PCLK); #1;
        cpu_req3 = 1'b0;
        @(posedge PCLK); #1;
        cpu_req3 = 1'b1; cpu_addr3 = 32'h0001_2000;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        checks++; if (PSEL3 !== 3'b100) begin errors++; $display("FAIL ns3_slot2_psel: got %b want 100", PSEL3); end
        repeat (2) begin @(posedge PCLK); #1; end
        @(negedge PCLK);
        checks++; if (cpu_stall3 !== 1'b0 || cpu_err3 !== 1'b0 || cpu_rdata3 !== 32'hCAFE_0002) begin errors++; $display("FAIL ns3_slot2_resp: stall %b err %b rdata %h want 0/0/cafe0002", cpu_stall3, cpu_err3, cpu_rdata3); end
        @(posedge PCLK); #1;
        cpu_req3 = 1'b0;
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 32'h0001_0040, 32'h0, 1000, 32'h7777_7777, 1'b0, 1'b0);
        checks++; if (o_en_first !== 2 || o_en_last !== TO + 1) begin errors++; $display("FAIL timeout_access_cycles: got %0d..%0d want 2..%0d", o_en_first, o_en_last, TO + 1); end
        checks++; if (o_sel_last !== TO + 1) begin errors++; $display("FAIL timeout_psel_drop: last %0d want %0d", o_sel_last, TO + 1); end
        checks++; if (o_resp !== TO + 2) begin errors++; $display("FAIL timeout_stall: got %0d want %0d", o_resp, TO + 2); end
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin errors++; $display("FAIL timeout_resp: err %b rdata %h want 1/0", o_err, o_rdata); end
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0000; cpu_wdata = 32'h0;
        PREADY_in = '0;
        repeat (3) begin @(posedge PCLK); #1; end
        checks++; if (PENABLE !== 1'b1 || PSEL !== 4'b0001) begin errors++; $display("FAIL midreset_pre: penable %b psel %b want 1/0001", PENABLE, PSEL); end
        #2 PRESETn = 1'b1;
        #1;
        checks++; if (PSEL !== '0 || PENABLE !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL midreset_async: psel %b penable %b stall %b want 0/0/0", PSEL, PENABLE, cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL midreset_no_err: got %b want 0", cpu_err); end
        @(negedge PCLK);
        PRESETn = 1'b0; cpu_req = 1'b0;
        @(posedge PCLK); #1;
        do_xfer(1'b1, 32'h0001_0008, 32'h5555_AAAA, 1, 32'h0, 1'b0, 1'b0);
        checks++; if (o_resp !== 4 || o_err !== 1'b0 || o_sel_or !== 4'b0001) begin errors++; $display("FAIL midreset_fresh: resp %0d err %b psel %b want 4/0/0001", o_resp, o_err, o_sel_or); end
    endtask

    task automatic test_back_to_back();
        do_xfer(1'b1, 32'h0001_1000, 32'h0101_0101, 0, 32'h0, 1'b0, 1'b1);
        checks++; if (o_resp !== 3) begin errors++; $display("FAIL b2b_first: got %0d want 3", o_resp); end
        do_xfer(1'b0, 32'h0001_2004, 32'h0, 0, 32'h2222_3333, 1'b0, 1'b0);
        checks++; if (o_sel_first !== 1) begin errors++; $display("FAIL b2b_setup_gap: setup at %0d want 1 after IDLE capture", o_sel_first); end
        checks++; if (o_resp !== 3 || o_rdata !== 32'h2222_3333) begin errors++; $display("FAIL b2b_second: resp %0d rdata %h want 3/22223333", o_resp, o_rdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, wd, rd;
            logic we, se, kp, ok;
            int w, er;
            logic [31:0] exp_rd;
            logic exp_er;
            a = $urandom;
            a[31:16] = ($urandom_range(0, 7) == 0) ? 16'(32'h0003 + $urandom_range(0, 100)) : 16'h0001;
            we = 1'($urandom); wd = $urandom; rd = $urandom; se = ($urandom_range(0, 3) == 0);
            w = $urandom_range(0, 10);
            kp = (n != 39) && 1'($urandom);
            ok = exp_ok(a);
            er = exp_resp(a, w);
            exp_er = !ok || (w >= TO) || se;
            exp_rd = (ok && !we && w < TO) ? rd : 32'd0;
            do_xfer(we, a, wd, w, rd, se, kp);
            checks++; if (o_resp !== er) begin errors++; $display("FAIL rand%0d_stall: got %0d want %0d", n, o_resp, er); end
            checks++; if (o_err !== exp_er) begin errors++; $display("FAIL rand%0d_err: got %b want %b", n, o_err, exp_er); end
            if (ok) begin
                checks++; if (o_rdata !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", n, o_rdata, exp_rd); end
                checks++; if (o_sel_or !== NS'(1 << a[13:12]) || o_addr_moves !== 0) begin errors++; $display("FAIL rand%0d_bus: psel %b moves %0d want %b/0", n, o_sel_or, o_addr_moves, NS'(1 << a[13:12])); end
            end else begin
                checks++; if (o_sel_or !== '0) begin errors++; $display("FAIL rand%0d_nosel: got %b want 0", n, o_sel_or); end
            end
        end
    endtask

    initial begin
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        PRDATA_in = '0; PREADY_in = '0; PSLVERR_in = '0;
        cpu_req3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
        PREADY3 = 3'b111; PSLVERR3 = 3'b000;
        PRDATA3 = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        test_reset();
        test_store_zero_wait();
        test_load_wait();
        test_slverr();
        test_decode_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
        $fatal(1);
    end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB master for the simpleRisc SoC peripheral bus. Converts a held CPU load/store request into a two-phase APB transfer, decodes the target slave (UART, timer, I2C, etc.), and stalls the core until the slave completes. It also returns read data and error status to the core. It drives PSEL/PENABLE/PWRITE/PADDR/PWDATA into the APB slave wrappers and muxes their PRDATA/PREADY/PSLVERR back.

## Interface
Parameters:
- NUM_SLAVES, 4, number of APB slaves (1..4)
- BASE_HI, 16'h0001, required value of cpu_addr[31:16] for a peripheral access
- TIMEOUT, 255, maximum ACCESS cycles without PREADY before abort (1..255)

Ports:
- PCLK  in  1  bus clock; single clock domain
- PRESETn  in  1  reset, asynchronous, active-high (port keeps codebase name; 1 = reset)
- cpu_req  in  1  peripheral access request; held by core until cpu_stall falls
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid in RESP cycle
- cpu_stall  out  1  freeze core while transfer is pending
- cpu_err  out  1  transfer failed (decode, PSLVERR, timeout), valid in RESP cycle
- PADDR  out  32  APB address
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA_in  in  32*NUM_SLAVES  slave read data, slave i at bits [32i+31:32i]
- PREADY_in  in  NUM_SLAVES  per-slave ready
- PSLVERR_in  in  NUM_SLAVES  per-slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, cpu_req=1: capture cpu_addr, cpu_we and cpu_wdata into PADDR, PWRITE and PWDATA. Slave index is cpu_addr[13:12].
  - Decode OK (cpu_addr[31:16]==BASE_HI and index<NUM_SLAVES): go to SETUP, PSEL[index]=1.
  - Decode fail: go to RESP with err=1. No PSEL asserted.
- SETUP: PSEL=1, PENABLE=0. Always go to ACCESS next.
- ACCESS: PSEL=1, PENABLE=1. The timeout counter increments each ACCESS cycle.
  - PREADY_in[index]=1: sample PSLVERR_in[index] into err. On a read, capture PRDATA_in slice into cpu_rdata; on a write, cpu_rdata is 0. Go to RESP.
  - Counter reaches TIMEOUT with PREADY=0: abort, set err=1, cpu_rdata=0, go to RESP.
- RESP: PSEL=0, PENABLE=0, cpu_stall=0, cpu_err=err. Unconditionally go to IDLE. A cpu_req present in RESP is ignored, because it belongs to the completing instruction.
- cpu_stall = cpu_req & (state != RESP), and 0 while PRESETn=1.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. They hold their values after the transfer until the next capture.
- cpu_rdata and cpu_err hold until the next capture in IDLE.
- PREADY, PRDATA and PSLVERR of non-selected slaves are ignored.

## Timing
- Reset (asynchronous, PRESETn=1) sets state IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, cpu_rdata, cpu_err and the counter all go to 0, and cpu_stall is 0.
- Reset mid-transfer drops PSEL/PENABLE immediately, with no completion and no error reported.
- Zero-wait transfer: request cycle 0 (IDLE), SETUP cycle 1, ACCESS cycle 2 with PREADY=1, RESP cycle 3. cpu_stall is high in cycles 0-2, so 3 stall cycles.
- Each PREADY wait state adds 1 cycle.
- Decode error: IDLE cycle 0, RESP cycle 1, so 1 stall cycle.
- Timeout: the abort occurs after TIMEOUT ACCESS cycles, so RESP arrives at cycle TIMEOUT+2.
- Back-to-back requests: the next transfer's SETUP is no earlier than 2 cycles after RESP (RESP, then IDLE capture).

## Test plan
- Store 0x0001_3004 / 0xA5A5_5A5A, PREADY_in[3]=1 immediately:
  - PSEL=4'b1000 in cycles 1-2, PENABLE only in cycle 2, PWDATA=0xA5A5_5A5A.
  - cpu_stall high for 3 cycles, cpu_err=0.
- Load 0x0001_2000, slave 2 holds PREADY low for 2 cycles, then PREADY=1 with PRDATA=0x1234_5678:
  - 5 stall cycles, cpu_rdata=0x1234_5678 in RESP.
  - PADDR stable throughout.
- Load slave 1 with PSLVERR_in[1]=1 at PREADY: cpu_err=1 in RESP, transfer ends normally.
- Address 0x0002_0000 (base mismatch), and with NUM_SLAVES=3 address 0x0001_3000:
  - No PSEL bit ever set.
  - RESP one cycle after request, cpu_err=1.
- TIMEOUT=8, slave never ready:
  - Exactly 8 ACCESS cycles, then PSEL/PENABLE drop.
  - cpu_err=1, cpu_rdata=0, stall released at cycle 10.
- Assert PRESETn during the 2nd ACCESS cycle:
  - PSEL, PENABLE and cpu_stall go to 0 asynchronously.
  - After release, a fresh request completes normally.
